// File: rtl/chip2chip_pkg.sv
// chip2chip_pkg: shared types and defaults for both ends of the chip-to-chip link
package chip2chip_pkg;

    localparam int DEF_DATA_W         = 3;
    localparam int DEF_TIMEOUT_CYCLES = 200_000_000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_VALID = 3'd1,
        CAPTURE    = 3'd2,
        RELEASE    = 3'd3,
        ABORT      = 3'd4
    } state_t;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser for an asynchronous input bundle
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r [STAGES];

    // Shift the bundle through STAGES flops; only the last stage is used downstream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r <= '{default: '0};
        end else begin
            r[0] <= d;
            for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
        end
    end

    assign q = r[STAGES-1];

endmodule

// File: rtl/slave_control.sv
// slave_control: receive-side handshake controller with watchdog for the chip-to-chip link
module slave_control
    import chip2chip_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              request_i,
    input  logic              notice_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              notice_led_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [3:0]        rx_cnt_o
);

    localparam logic [27:0] TERM = 28'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [27:0]       timer;
    logic              request_s;
    logic              notice_s;
    logic              valid_s;
    logic [DATA_W-1:0] data_s;

    sync_chain #(.WIDTH(DATA_W + 3), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({request_i, notice_i, valid_i, data_i}),
        .q     ({request_s, notice_s, valid_s, data_s})
    );

    // Handshake FSM; every output is registered and updated alongside the state it reflects
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            ack_o        <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            notice_led_o <= 1'b0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
            rx_cnt_o     <= '0;
        end else begin
            data_valid_o <= 1'b0;
            case (state)
                IDLE: if (request_s) begin
                    state        <= WAIT_VALID;
                    ack_o        <= 1'b1;
                    busy_o       <= 1'b1;
                    timer        <= '0;
                    timeout_o    <= 1'b0;
                    notice_led_o <= notice_s;
                end
                WAIT_VALID: if (valid_s) begin
                    state        <= CAPTURE;
                    data_o       <= data_s;
                    data_valid_o <= 1'b1;
                    rx_cnt_o     <= rx_cnt_o + 4'd1;
                    notice_led_o <= 1'b0;
                end else if (timer == TERM) begin
                    state        <= ABORT;
                    ack_o        <= 1'b0;
                    timeout_o    <= 1'b1;
                    notice_led_o <= 1'b0;
                end else begin
                    timer        <= (&timer) ? timer : timer + 28'd1;
                    notice_led_o <= notice_s;
                end
                CAPTURE: begin
                    state <= RELEASE;
                    ack_o <= 1'b0;
                end
                RELEASE: if (!valid_s) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                ABORT: if (!request_s && !valid_s) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    ack_o        <= 1'b0;
                    busy_o       <= 1'b0;
                    notice_led_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_control.sv
// tb_slave_control: directed and randomized checks of slave_control against a transaction-level model
module tb_slave_control;

    localparam int DW = 3;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          request_i = 1'b0;
    logic          notice_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          ack_o;
    logic [DW-1:0] data_o;
    logic          data_valid_o;
    logic          notice_led_o;
    logic          busy_o;
    logic          timeout_o;
    logic [3:0]    rx_cnt_o;

    int passed = 0;
    int total = 0;

    int unsigned exp_cnt = 0;
    logic [DW-1:0] exp_data = '0;

    slave_control #(.DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .request_i    (request_i),
        .notice_i     (notice_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ack_o        (ack_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .notice_led_o (notice_led_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .rx_cnt_o     (rx_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o !== 1'b0 && n < 20) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, busy_o}, 32'd0);
    endtask

    // Raise request in IDLE; ack must appear on the third edge and clear any old timeout
    task automatic start(input logic nb);
        request_i = 1'b1;
        notice_i  = nb;
        tick(2);
        check("ack_early", {31'd0, ack_o}, 32'd0);
        tick(1);
        check("ack_rise", {31'd0, ack_o}, 32'd1);
        check("timeout_clr", {31'd0, timeout_o}, 32'd0);
        check("busy_wait", {31'd0, busy_o}, 32'd1);
    endtask

    // Present a symbol; expect the capture pulse three edges later and ack low one edge after
    task automatic finish(input logic [DW-1:0] d);
        valid_i = 1'b1;
        data_i  = d;
        tick(2);
        check("dv_early", {31'd0, data_valid_o}, 32'd0);
        tick(1);
        exp_cnt  = (exp_cnt + 1) % 16;
        exp_data = d;
        check("dv_pulse", {31'd0, data_valid_o}, 32'd1);
        check("data_cap", {29'd0, data_o}, {29'd0, exp_data});
        tick(1);
        check("ack_fall", {31'd0, ack_o}, 32'd0);
        check("dv_single", {31'd0, data_valid_o}, 32'd0);
        check("rx_cnt", {28'd0, rx_cnt_o}, exp_cnt);
        valid_i   = 1'b0;
        request_i = 1'b0;
        notice_i  = 1'b0;
        wait_idle("release_idle");
        check("data_hold", {29'd0, data_o}, {29'd0, exp_data});
    endtask

    task automatic transfer(input logic [DW-1:0] d, input int dly, input logic nb);
        start(nb);
        tick(dly);
        check("notice_led", {31'd0, notice_led_o}, {31'd0, nb});
        finish(d);
    endtask

    initial begin
        int n;
        logic seen;
        tick(3);
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_data", {29'd0, data_o}, 32'd0);
        check("rst_cnt", {28'd0, rx_cnt_o}, 32'd0);
        check("rst_to", {31'd0, timeout_o}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        transfer(3'b101, 20, 1'b1);

        start(1'b0);
        n = 0;
        while (ack_o === 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("ack_high_cycles", n, TO);
        check("timeout_set", {31'd0, timeout_o}, 32'd1);
        check("abort_busy", {31'd0, busy_o}, 32'd1);
        request_i = 1'b0;
        wait_idle("abort_idle");
        check("timeout_sticky", {31'd0, timeout_o}, 32'd1);
        start(1'b0);
        tick(4);
        finish(3'b110);

        valid_i = 1'b1;
        data_i  = 3'b011;
        seen    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            seen |= data_valid_o | ack_o;
        end
        valid_i = 1'b0;
        tick(4);
        check("idle_no_activity", {31'd0, seen}, 32'd0);
        check("idle_data", {29'd0, data_o}, {29'd0, exp_data});
        check("idle_cnt", {28'd0, rx_cnt_o}, exp_cnt);

        for (int i = 0; i < 16; i++) transfer(DW'(i % 8), $urandom_range(3, 40), 1'($urandom));
        for (int i = 0; i < 8; i++) transfer(DW'($urandom), $urandom_range(3, 40), 1'($urandom));

        start(1'b0);
        tick(TO - 3);
        finish(3'b010);
        check("edge_no_timeout", {31'd0, timeout_o}, 32'd0);

        start(1'b1);
        tick(3);
        check("pre_rst_led", {31'd0, notice_led_o}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        exp_cnt  = 0;
        exp_data = '0;
        check("mid_rst_ack", {31'd0, ack_o}, 32'd0);
        check("mid_rst_led", {31'd0, notice_led_o}, 32'd0);
        check("mid_rst_data", {29'd0, data_o}, 32'd0);
        check("mid_rst_cnt", {28'd0, rx_cnt_o}, exp_cnt);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        request_i = 1'b0;
        notice_i  = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(2);
        transfer(3'b111, 5, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
